// File: rtl/mnvg_pkg.sv
// Shared constants, tuple type and tree-depth helper for the min1/min2/index finder.
package mnvg_pkg;

  localparam int W_DEF     = 6;
  localparam int NLANE_DEF = 4;
  localparam int IDXW_DEF  = 4;
  localparam int MAG_W     = W_DEF - 1;

  localparam logic [MAG_W-1:0] MAX_MAG = {MAG_W{1'b1}};

  typedef struct packed {
    logic [MAG_W-1:0]    min1;
    logic [MAG_W-1:0]    min2;
    logic [IDXW_DEF-1:0] idx;
  } mnvg_tuple_t;

  function automatic int tree_levels(input int nlane);
    return $clog2(nlane);
  endfunction

endpackage

// File: rtl/mnvg_merge.sv
// Combinational merge of two (min1, min2, idx) tuples; A is the earlier, lower-index side.
module mnvg_merge
  import mnvg_pkg::*;
#(
  parameter int MW = MAG_W,
  parameter int IW = IDXW_DEF
) (
  input  logic [MW-1:0] a_min1,
  input  logic [MW-1:0] a_min2,
  input  logic [IW-1:0] a_idx,
  input  logic [MW-1:0] b_min1,
  input  logic [MW-1:0] b_min2,
  input  logic [IW-1:0] b_idx,
  output logic [MW-1:0] min1,
  output logic [MW-1:0] min2,
  output logic [IW-1:0] idx
);

  // Ties resolve to A so the lowest global index keeps min1.
  always_comb begin
    min1 = a_min1;
    min2 = a_min2;
    idx  = a_idx;
    if (a_min1 <= b_min1) begin
      min1 = a_min1;
      idx  = a_idx;
      min2 = (b_min1 < a_min2) ? b_min1 : a_min2;
    end else begin
      min1 = b_min1;
      idx  = b_idx;
      min2 = (a_min1 < b_min2) ? a_min1 : b_min2;
    end
  end

endmodule

// File: rtl/mnvg_tree_pipelined.sv
// Pipelined min1/min2/index finder: registered binary compare tree plus a per-row
// accumulator so rows may span several beats of NLANE magnitudes.
module mnvg_tree_pipelined
  import mnvg_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int NLANE = NLANE_DEF,
  parameter int IDXW  = IDXW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic [NLANE*(W-1)-1:0] x,
  output logic                   out_valid,
  output logic [W-2:0]           min1,
  output logic [W-2:0]           min2,
  output logic [IDXW-1:0]        idx,
  output logic                   ovf
);

  localparam int MW   = W - 1;
  localparam int LVL  = tree_levels(NLANE);
  localparam int NINT = NLANE - 1;
  localparam int PW   = IDXW + LVL + 2;
  localparam logic [MW-1:0] ONES = {MW{1'b1}};

  logic [MW-1:0]   leaf_min1_s [NLANE];
  logic [IDXW-1:0] leaf_idx_s  [NLANE];

  // Internal nodes in heap order: node i has children 2i+1 (A) and 2i+2 (B).
  logic [MW-1:0]   node_min1_r [NINT];
  logic [MW-1:0]   node_min2_r [NINT];
  logic [IDXW-1:0] node_idx_r  [NINT];
  logic [MW-1:0]   mg_min1_s   [NINT];
  logic [MW-1:0]   mg_min2_s   [NINT];
  logic [IDXW-1:0] mg_idx_s    [NINT];

  logic [LVL-1:0] vld_r;
  logic [LVL-1:0] lst_r;

  for (genvar k = 0; k < NLANE; k++) begin : g_leaf
    assign leaf_min1_s[k] = x[k*MW +: MW];
    assign leaf_idx_s[k]  = IDXW'(k);
  end

  for (genvar i = 0; i < NINT; i++) begin : g_node
    logic [MW-1:0]   a_min1_s;
    logic [MW-1:0]   a_min2_s;
    logic [IDXW-1:0] a_idx_s;
    logic [MW-1:0]   b_min1_s;
    logic [MW-1:0]   b_min2_s;
    logic [IDXW-1:0] b_idx_s;

    if (2*i+1 >= NINT) begin : g_leaf_kids
      assign a_min1_s = leaf_min1_s[2*i+1-NINT];
      assign a_min2_s = ONES;
      assign a_idx_s  = leaf_idx_s[2*i+1-NINT];
      assign b_min1_s = leaf_min1_s[2*i+2-NINT];
      assign b_min2_s = ONES;
      assign b_idx_s  = leaf_idx_s[2*i+2-NINT];
    end else begin : g_node_kids
      assign a_min1_s = node_min1_r[2*i+1];
      assign a_min2_s = node_min2_r[2*i+1];
      assign a_idx_s  = node_idx_r[2*i+1];
      assign b_min1_s = node_min1_r[2*i+2];
      assign b_min2_s = node_min2_r[2*i+2];
      assign b_idx_s  = node_idx_r[2*i+2];
    end

    mnvg_merge #(.MW(MW), .IW(IDXW)) u_merge (
      .a_min1 (a_min1_s),
      .a_min2 (a_min2_s),
      .a_idx  (a_idx_s),
      .b_min1 (b_min1_s),
      .b_min2 (b_min2_s),
      .b_idx  (b_idx_s),
      .min1   (mg_min1_s[i]),
      .min2   (mg_min2_s[i]),
      .idx    (mg_idx_s[i])
    );
  end

  // Tree ranks: each internal node registers its merge result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NINT; i++) begin
        node_min1_r[i] <= {MW{1'b0}};
        node_min2_r[i] <= {MW{1'b0}};
        node_idx_r[i]  <= {IDXW{1'b0}};
      end
    end else begin
      for (int i = 0; i < NINT; i++) begin
        node_min1_r[i] <= mg_min1_s[i];
        node_min2_r[i] <= mg_min2_s[i];
        node_idx_r[i]  <= mg_idx_s[i];
      end
    end
  end

  // Beat valid and row-end marker travel alongside the tree data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_r <= {LVL{1'b0}};
      lst_r <= {LVL{1'b0}};
    end else begin
      vld_r[0] <= in_valid;
      lst_r[0] <= in_valid & in_last;
      for (int l = 1; l < LVL; l++) begin
        vld_r[l] <= vld_r[l-1];
        lst_r[l] <= lst_r[l-1];
      end
    end
  end

  logic [MW-1:0]   acc_min1_r;
  logic [MW-1:0]   acc_min2_r;
  logic [IDXW-1:0] acc_idx_r;
  logic [IDXW:0]   beat_r;
  logic            in_row_r;
  logic            ovf_acc_r;
  logic            out_valid_r;
  logic [MW-1:0]   min1_r;
  logic [MW-1:0]   min2_r;
  logic [IDXW-1:0] idx_r;
  logic            ovf_r;

  logic [PW-1:0]   base_s;
  logic [PW-1:0]   top_pos_s;
  logic [IDXW-1:0] off_idx_s;
  logic            beat_ovf_s;
  logic [MW-1:0]   am_min1_s;
  logic [MW-1:0]   am_min2_s;
  logic [IDXW-1:0] am_idx_s;
  logic [MW-1:0]   nxt_min1_s;
  logic [MW-1:0]   nxt_min2_s;
  logic [IDXW-1:0] nxt_idx_s;
  logic            nxt_ovf_s;

  // First global position of this beat, and its last position for the overflow test.
  assign base_s     = PW'(beat_r) << LVL;
  assign top_pos_s  = base_s + PW'(NLANE - 1);
  assign beat_ovf_s = |top_pos_s[PW-1:IDXW];
  assign off_idx_s  = node_idx_r[0] + base_s[IDXW-1:0];

  mnvg_merge #(.MW(MW), .IW(IDXW)) u_acc_merge (
    .a_min1 (acc_min1_r),
    .a_min2 (acc_min2_r),
    .a_idx  (acc_idx_r),
    .b_min1 (node_min1_r[0]),
    .b_min2 (node_min2_r[0]),
    .b_idx  (off_idx_s),
    .min1   (am_min1_s),
    .min2   (am_min2_s),
    .idx    (am_idx_s)
  );

  // A row's first beat loads the tree tuple; later beats merge into the accumulator.
  always_comb begin
    nxt_min1_s = am_min1_s;
    nxt_min2_s = am_min2_s;
    nxt_idx_s  = am_idx_s;
    nxt_ovf_s  = ovf_acc_r | beat_ovf_s;
    if (!in_row_r) begin
      nxt_min1_s = node_min1_r[0];
      nxt_min2_s = node_min2_r[0];
      nxt_idx_s  = off_idx_s;
    end else begin
      nxt_min1_s = am_min1_s;
      nxt_min2_s = am_min2_s;
      nxt_idx_s  = am_idx_s;
    end
  end

  // Accumulator and registered row-result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_min1_r  <= {MW{1'b0}};
      acc_min2_r  <= {MW{1'b0}};
      acc_idx_r   <= {IDXW{1'b0}};
      beat_r      <= {(IDXW+1){1'b0}};
      in_row_r    <= 1'b0;
      ovf_acc_r   <= 1'b0;
      out_valid_r <= 1'b0;
      min1_r      <= {MW{1'b0}};
      min2_r      <= {MW{1'b0}};
      idx_r       <= {IDXW{1'b0}};
      ovf_r       <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      if (vld_r[LVL-1]) begin
        if (lst_r[LVL-1]) begin
          min1_r      <= nxt_min1_s;
          min2_r      <= nxt_min2_s;
          idx_r       <= nxt_idx_s;
          ovf_r       <= nxt_ovf_s;
          out_valid_r <= 1'b1;
          beat_r      <= {(IDXW+1){1'b0}};
          ovf_acc_r   <= 1'b0;
          in_row_r    <= 1'b0;
        end else begin
          acc_min1_r <= nxt_min1_s;
          acc_min2_r <= nxt_min2_s;
          acc_idx_r  <= nxt_idx_s;
          ovf_acc_r  <= nxt_ovf_s;
          in_row_r   <= 1'b1;
          beat_r     <= (&beat_r) ? beat_r : beat_r + (IDXW+1)'(1);
        end
      end else begin
        beat_r <= beat_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign min1      = min1_r;
  assign min2      = min2_r;
  assign idx       = idx_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_mnvg_tree_pipelined.sv
// Randomised and directed bench for mnvg_tree_pipelined against a row-level reference model.
module tb_mnvg_tree_pipelined;
  import mnvg_pkg::*;

  localparam int W     = 6;
  localparam int NLANE = 4;
  localparam int IDXW  = 4;
  localparam int MW    = W - 1;
  localparam int LVL   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_last = 1'b0;
  logic [NLANE*MW-1:0] x = '0;
  logic               out_valid;
  logic [MW-1:0]      min1;
  logic [MW-1:0]      min2;
  logic [IDXW-1:0]    idx;
  logic               ovf;

  mnvg_tree_pipelined #(.W(W), .NLANE(NLANE), .IDXW(IDXW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .x         (x),
    .out_valid (out_valid),
    .min1      (min1),
    .min2      (min2),
    .idx       (idx),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    mnvg_tuple_t t;
    bit          ovf;
  } exp_t;

  exp_t        exp_q[$];
  int          row_vals[$];
  mnvg_tuple_t held_t = '0;
  bit          held_ovf = 1'b0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: smallest, second smallest of the multiset, first position of the minimum.
  task automatic close_row(input int due);
    int   s[$];
    int   first;
    exp_t e;
    s = row_vals;
    s.sort();
    first = 0;
    for (int i = row_vals.size() - 1; i >= 0; i--)
      if (row_vals[i] == s[0]) first = i;
    e.due    = due;
    e.t.min1 = MW'(s[0]);
    e.t.min2 = MW'(s[1]);
    e.t.idx  = IDXW'(first % (1 << IDXW));
    e.ovf    = row_vals.size() > (1 << IDXW);
    exp_q.push_back(e);
    row_vals.delete();
  endtask

  task automatic send(input bit v, input bit l, input int vals[NLANE]);
    in_valid = v;
    in_last  = l;
    for (int k = 0; k < NLANE; k++) x[k*MW +: MW] = MW'(vals[k]);
    if (v) begin
      for (int k = 0; k < NLANE; k++) row_vals.push_back(vals[k]);
      if (l) close_row(cyc + 1 + LVL);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_last  = 1'($urandom_range(0, 1));
      x        = NLANE*MW'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_valid"}, int'(out_valid), 0);
    check_eq({tag, "_min1"}, int'(min1), 0);
    check_eq({tag, "_min2"}, int'(min2), 0);
    check_eq({tag, "_idx"}, int'(idx), 0);
    check_eq({tag, "_ovf"}, int'(ovf), 0);
  endtask

  // Per-cycle monitor: pulse with the due result, otherwise outputs hold the last result.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      check_eq("pulse_valid", int'(out_valid), 1);
      check_eq("pulse_min1", int'(min1), int'(exp_q[0].t.min1));
      check_eq("pulse_min2", int'(min2), int'(exp_q[0].t.min2));
      check_eq("pulse_idx", int'(idx), int'(exp_q[0].t.idx));
      check_eq("pulse_ovf", int'(ovf), int'(exp_q[0].ovf));
      held_t   = exp_q[0].t;
      held_ovf = exp_q[0].ovf;
      void'(exp_q.pop_front());
    end else begin
      check_eq("idle_valid", int'(out_valid), 0);
      check_eq("hold_min1", int'(min1), int'(held_t.min1));
      check_eq("hold_min2", int'(min2), int'(held_t.min2));
      check_eq("hold_idx", int'(idx), int'(held_t.idx));
      check_eq("hold_ovf", int'(ovf), int'(held_ovf));
    end
  end

  initial begin
    int vals[NLANE];
    int nb;
    int narrow;
    int waited;

    #1;
    check_zero_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);

    // Directed single-beat rows, ties and two-beat rows.
    send(1'b1, 1'b1, '{5, 9, 2, 7});
    idle(3);
    send(1'b1, 1'b1, '{4, 4, 4, 4});
    idle(3);
    send(1'b1, 1'b0, '{6, 7, 8, 9});
    send(1'b1, 1'b1, '{10, 3, 12, 5});
    idle(3);
    send(1'b1, 1'b0, '{8, 8, 1, 8});
    send(1'b1, 1'b1, '{1, 9, 9, 9});
    idle(3);

    // Back-to-back rows with no gap between B and C.
    send(1'b1, 1'b1, '{3, 3, 3, 1});
    idle(2);
    send(1'b1, 1'b0, '{7, 3, 9, 11});
    send(1'b1, 1'b1, '{12, 4, 13, 14});
    send(1'b1, 1'b1, '{6, 5, 3, 8});
    idle(4);

    // Index overflow row, then a normal row.
    for (int b = 0; b < 5; b++) begin
      vals = '{20, 20, 20, 20};
      if (b == 4) vals[1] = 0;
      send(1'b1, b == 4, vals);
    end
    send(1'b1, 1'b1, '{11, 2, 30, 2});
    idle(4);

    // Randomised rows with in-row bubbles and ties.
    for (int r = 0; r < 40; r++) begin
      nb = $urandom_range(1, 6);
      narrow = $urandom_range(0, 1);
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < NLANE; k++)
          vals[k] = narrow ? $urandom_range(0, 3) : $urandom_range(0, int'(MAX_MAG));
        send(1'b1, b == nb - 1, vals);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle($urandom_range(0, 2));
    end
    idle(4);

    // Asynchronous reset in the middle of a row.
    send(1'b1, 1'b0, '{1, 1, 1, 1});
    #2;
    rst = 1'b0;
    exp_q.delete();
    row_vals.delete();
    held_t   = '0;
    held_ovf = 1'b0;
    #1;
    check_zero_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    send(1'b1, 1'b1, '{4, 6, 8, 2});

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      idle(1);
      waited++;
    end
    check_eq("drain_pending", exp_q.size(), 0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mnvg_tree_pipelined.md
Name: mnvg_tree_pipelined

Overview:
- Parametrised, fully pipelined min1/min2/index finder for the min-sum check-node unit.
- Accepts NLANE magnitudes per beat and reduces them through a registered binary compare tree.
- Accumulates across multiple beats, so rows with degree greater than NLANE are handled.
- Once per row it reports the smallest magnitude, the second-smallest magnitude, the global position of the smallest, and an index-overflow flag.

Parameters:
- W, 6: message width. Magnitudes are W-1 bits.
- NLANE, 4: lanes per beat. Must be a power of 2 and at least 2.
- IDXW, 4: width of the global min1 index. Must be at least log2(NLANE).
- LVL (localparam), log2(NLANE): number of tree levels.

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low. Asserted when 0.
- in_valid  in  1  beat present on x this cycle.
- in_last  in  1  final beat of the current row. Qualified by in_valid.
- x  in  NLANE*(W-1)  magnitudes. Lane k occupies bits [(k+1)*(W-1)-1 : k*(W-1)].
- out_valid  out  1  one-cycle pulse: row result is valid.
- min1  out  W-1  smallest magnitude in the row.
- min2  out  W-1  second-smallest magnitude in the row. Equals min1 when the minimum is duplicated.
- idx  out  IDXW  global position of min1, equal to (beat*NLANE + lane) mod 2^IDXW.
- ovf  out  1  some position in the row did not fit in IDXW bits.

Behaviour:
- Reset (rst=0): every register clears immediately, without waiting for a clock edge.
  - Outputs go to out_valid=0, min1=0, min2=0, idx=0, ovf=0.
  - The beat counter and all tree-stage valids clear. Any partial row is discarded.
  - The first valid beat after reset release starts a new row.
- Merge rule for two tuples A (earlier, lower index) and B:
  - If A.min1 <= B.min1: min1=A.min1, idx=A.idx, min2=min(A.min2, B.min1).
  - Otherwise: min1=B.min1, idx=B.idx, min2=min(B.min2, A.min1).
  - Ties always resolve to A, so the lowest global index wins.
- Leaf tuple for a single lane k: (min1=x_k, min2=all-ones, idx=k).
- Tree: LVL levels of merge nodes, with one register rank after each level.
  - valid and last travel in lockstep with the data.
- Accumulator stage: one register rank after the tree. It holds acc tuple, beat counter, row-start flag and sticky ovf.
  - On a valid tree output, the tree idx is offset by beat*NLANE.
  - If the row-start flag is set, acc loads the offset tuple. Otherwise acc is merged with it, with acc as A.
  - beat increments on every valid tree output.
  - If a valid tree output has last=1: load min1/min2/idx/ovf from the merged value and pulse out_valid for 1 cycle. Then clear beat and ovf and set row-start.
- Latency: from the clock edge sampling in_valid&in_last to out_valid high is LVL+1 cycles (3 for NLANE=4).
- Throughput: one beat per cycle, with no backpressure.
  - in_valid=0 bubbles propagate through the pipeline and do not disturb acc.
  - A new row may start on the cycle after in_last.
- ovf is set when beat*NLANE + NLANE-1 >= 2^IDXW for any beat of the row. It is reported with that row and cleared for the next.
- The beat counter saturates at its maximum and does not wrap. It is IDXW+1 bits wide.
- Between pulses, the outputs hold their last row result.
- in_last with in_valid=0 is ignored.

Decomposition:
- Shared package (mnvg_pkg):
  - magnitude width constant.
  - tuple typedef {min1, min2, idx}.
  - MAX_MAG all-ones constant.
  - clog2-based LVL helper.
- Sub-module mnvg_merge: a combinational two-tuple merge node implementing the rule above.
  - Instanced NLANE-1 times in the tree and once in the accumulator.
  - Tie behaviour therefore has a single definition.

Test Plan (W=6, NLANE=4, IDXW=4; lanes listed 0..3):
- Single-beat row, lanes 5,9,2,7 with in_last=1: 3 cycles later out_valid=1, min1=2, min2=5, idx=2, ovf=0. out_valid is a one-cycle pulse.
- Equal values, lanes 4,4,4,4 single beat: min1=4, min2=4, idx=0. Ties resolve to the lowest index.
- Two-beat row, beat0 = 6,7,8,9 and beat1 = 10,3,12,5 (last): min1=3, min2=5, idx=5. Then a cross-beat tie, beat0 = 8,8,1,8 and beat1 = 1,9,9,9 (last): min1=1, min2=1, idx=2.
- Back-to-back rows: row A single beat 3,3,3,1; two idle cycles; row B of two beats on consecutive cycles, with row C immediately after. Three pulses appear at the correct cycles with results 1/3/3, and there is no cross-row leakage.
- Overflow: 5-beat row, all lanes 20 except beat4 lane1 = 0. Result is min1=0, min2=20, idx=1 (17 mod 16), ovf=1. The next normal row reports ovf=0.
- Reset mid-row: drive rst=0 between edges after beat0 of a 2-beat row. All outputs read 0 before the next edge. Release, then send single-beat row 4,6,8,2: min1=2, min2=4, idx=3, with no stale merge.
